bcd_to_bin_converter: RTL and testbench

- Sequential converter from packed BCD to binary.
- Takes an 8-digit packed-BCD word, such as the value of the team's decimal event counter, and returns its binary value.
- Also reports how many digits are significant, for leading-zero blanking, and flags any illegal digit.
- Sits downstream of the decimal counter, on the consumer side of its 32-bit BCD count bus, and feeds arithmetic and display logic that need a binary value.

---
 rtl/bcd_to_bin_converter_if.sv | 24 ++
 rtl/bcd_to_bin_converter.sv | 99 +++++++++
 tb/tb_bcd_to_bin_converter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/bcd_to_bin_converter_if.sv
// Handshake and result bundle between a BCD producer and the BCD-to-binary converter.
interface bcd_to_bin_converter_if #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned BIN_W  = 27,
    parameter int unsigned CNT_W  = 4
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd_in;
    logic                  busy;
    logic                  done;
    logic [BIN_W-1:0]      bin_out;
    logic [CNT_W-1:0]      sig_digits;
    logic                  err;

    modport master (
        output start, bcd_in,
        input  busy, done, bin_out, sig_digits, err
    );

    modport slave (
        input  start, bcd_in,
        output busy, done, bin_out, sig_digits, err
    );
endinterface

// File: rtl/bcd_to_bin_converter.sv
// Sequential packed-BCD to binary converter, one digit per clock, most significant digit first.
// Also reports the significant digit count and flags illegal digits.
module bcd_to_bin_converter #(
    parameter int unsigned DIGITS = 8,
    parameter int unsigned BIN_W  = 27,
    parameter int unsigned CNT_W  = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    bcd_to_bin_converter_if.slave     bus
);
    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {StIdle, StConv} state_e;

    state_e               state_q;
    logic [4*DIGITS-1:0]  shreg_q;
    logic [BIN_W-1:0]     acc_q, acc_d;
    logic [IdxW-1:0]      idx_q;
    logic                 seen_q, seen_d;
    logic [CNT_W-1:0]     sig_q, sig_d;
    logic                 err_flag_q, err_flag_d;
    logic [3:0]           digit;
    logic                 last_digit;

    logic                 busy_q, done_q, err_q;
    logic [BIN_W-1:0]     bin_q;
    logic [CNT_W-1:0]     sig_out_q;

    always_comb begin
        digit      = shreg_q[4*DIGITS-1 -: 4];
        acc_d      = (acc_q << 3) + (acc_q << 1) + BIN_W'(digit);
        err_flag_d = err_flag_q | (digit > 4'd9);
        seen_d     = seen_q;
        sig_d      = sig_q;
        // First nonzero digit fixes the significant-digit count.
        if (digit != 4'd0 && !seen_q) begin
            seen_d = 1'b1;
            sig_d  = CNT_W'(DIGITS) - CNT_W'(idx_q);
        end
        last_digit = (idx_q == IdxW'(DIGITS - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            acc_q      <= '0;
            idx_q      <= '0;
            seen_q     <= 1'b0;
            sig_q      <= '0;
            err_flag_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bin_q      <= '0;
            sig_out_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        shreg_q    <= bus.bcd_in;
                        acc_q      <= '0;
                        seen_q     <= 1'b0;
                        sig_q      <= '0;
                        err_flag_q <= 1'b0;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= StConv;
                    end
                end
                StConv: begin
                    acc_q      <= acc_d;
                    err_flag_q <= err_flag_d;
                    seen_q     <= seen_d;
                    sig_q      <= sig_d;
                    shreg_q    <= shreg_q << 4;
                    idx_q      <= idx_q + 1'b1;
                    if (last_digit) begin
                        bin_q     <= err_flag_d ? '0 : acc_d;
                        sig_out_q <= err_flag_d ? '0 : sig_d;
                        err_q     <= err_flag_d;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.bin_out    = bin_q;
    assign bus.sig_digits = sig_out_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_bcd_to_bin_converter.sv
// Self-checking bench: directed cases plus random BCD words against an arithmetic reference model.
module tb_bcd_to_bin_converter;
    localparam int unsigned DIGITS = 8;
    localparam int unsigned BIN_W  = 27;
    localparam int unsigned CNT_W  = 4;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;

    bcd_to_bin_converter_if #(.DIGITS(DIGITS), .BIN_W(BIN_W), .CNT_W(CNT_W)) bus ();

    bcd_to_bin_converter #(.DIGITS(DIGITS), .BIN_W(BIN_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Reference: decimal value by plain arithmetic, sig = position of highest nonzero digit.
    task automatic model(input logic [31:0] bcd, output logic [31:0] bin, output logic [31:0] sig,
                         output logic [31:0] e);
        int unsigned v;
        logic [3:0]  d;
        v = 0; sig = 0; e = 0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            d = bcd[4*i +: 4];
            v = v * 10 + d;
            if (d > 9) e = 1;
            if (d != 0 && sig == 0) sig = i + 1;
        end
        bin = v;
        if (e != 0) begin
            bin = 0;
            sig = 0;
        end
    endtask

    // Waits for done from the negedge after the accepting edge; checks latency, busy and results.
    task automatic wait_result(input string tag, input logic [31:0] exp_bin,
                               input logic [31:0] exp_sig, input logic [31:0] exp_err);
        int n;
        int busy_cnt;
        n = 0;
        busy_cnt = 0;
        while (!bus.done && n < 20) begin
            if (bus.busy) busy_cnt++;
            @(negedge clk);
            n++;
        end
        check({tag, ".latency"}, n, DIGITS);
        check({tag, ".busy_cycles"}, busy_cnt, DIGITS);
        check({tag, ".busy_at_done"}, {31'b0, bus.busy}, 0);
        check({tag, ".bin"}, {5'b0, bus.bin_out}, exp_bin);
        check({tag, ".sig"}, {28'b0, bus.sig_digits}, exp_sig);
        check({tag, ".err"}, {31'b0, bus.err}, exp_err);
    endtask

    task automatic run_conv(input string tag, input logic [31:0] bcd, input logic [31:0] exp_bin,
                            input logic [31:0] exp_sig, input logic [31:0] exp_err);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = bcd;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.bcd_in = $urandom;
        wait_result(tag, exp_bin, exp_sig, exp_err);
        @(negedge clk);
        check({tag, ".done_pulse"}, {31'b0, bus.done}, 0);
    endtask

    logic [31:0] rb, rs, re, word;

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.bcd_in = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", {31'b0, bus.busy}, 0);
        check("rst.done", {31'b0, bus.done}, 0);
        check("rst.bin", {5'b0, bus.bin_out}, 0);
        check("rst.sig", {28'b0, bus.sig_digits}, 0);
        check("rst.err", {31'b0, bus.err}, 0);
        reset = 1'b0;

        run_conv("zero", 32'h0000_0000, 0, 0, 0);
        run_conv("seq", 32'h1234_5678, 32'h00BC_614E, 8, 0);
        run_conv("nines", 32'h9999_9999, 32'h05F5_E0FF, 8, 0);
        run_conv("d907", 32'h0000_0907, 32'h0000_038B, 3, 0);
        run_conv("illegal", 32'h0000_A001, 0, 0, 1);
        run_conv("one", 32'h0000_0001, 1, 1, 0);

        // start while busy is ignored; start in the done cycle is accepted
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd_in = 32'h0000_0055;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bcd_in = 32'h0;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.bcd_in = 32'h0000_0077;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bcd_in = 32'h0;
        begin
            int n;
            n = 0;
            while (!bus.done && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("ignore.latency", n + 3, DIGITS);
        end
        check("ignore.bin", {5'b0, bus.bin_out}, 55);
        check("ignore.sig", {28'b0, bus.sig_digits}, 2);
        bus.start = 1'b1;
        bus.bcd_in = 32'h0000_0010;
        @(negedge clk);
        bus.start = 1'b0;
        bus.bcd_in = 32'h0000_9999;
        check("b2b.busy", {31'b0, bus.busy}, 1);
        wait_result("b2b", 10, 2, 0);

        // reset mid-conversion aborts without a done pulse
        @(negedge clk);
        bus.start = 1'b1;
        bus.bcd_in = 32'h0000_1234;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort.busy", {31'b0, bus.busy}, 0);
        check("abort.bin", {5'b0, bus.bin_out}, 0);
        check("abort.sig", {28'b0, bus.sig_digits}, 0);
        reset = 1'b0;
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 12; i++) begin
                @(negedge clk);
                if (bus.done || bus.busy) seen_done++;
            end
            check("abort.no_done", seen_done, 0);
        end

        // random words, mostly legal digits with occasional illegal ones and leading zeros
        for (int k = 0; k < 24; k++) begin
            int lz;
            word = 0;
            lz = $urandom_range(0, DIGITS);
            for (int i = 0; i < DIGITS; i++) begin
                logic [3:0] d;
                d = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
                if (i >= DIGITS - lz) d = 4'd0;
                word[4*i +: 4] = d;
            end
            model(word, rb, rs, re);
            run_conv($sformatf("rnd%0d", k), word, rb, rs, re);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
